// File: rtl/fp_mult_ctrl.sv
// fp_mult_ctrl: two-requester binary32 multiplier with round-robin arbitration.
// One shared multiply/normalize/round datapath sequenced by an
// IDLE -> MULT -> NORM -> ROUND -> DONE FSM. Results are tagged with the
// requester ID and a status byte.
//
// Ports:
//   clk, rst              rising-edge clock, async active-high reset
//   reqN_valid/ready      request handshake, N = 0,1
//   reqN_a, reqN_b        binary32 operands
//   reqN_rnd              rounding mode (000 RNE, 001 RTZ, 010 RUP, 011 RDN,
//                         100 RNA, others RNE)
//   out_valid/out_ready   result handshake
//   out_z                 binary32 product
//   out_id                requester that issued the result
//   out_status            [0] zero [1] inf [2] nan [3] tiny [4] huge [5] inexact
//
// Build option: FP_MULT_CTRL_FAST_SPECIAL_EN -- operands that are NaN, inf,
// zero or denormal bypass the datapath and go IDLE -> DONE in one cycle.
// Results are identical with or without it.
module fp_mult_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [31:0] req0_a,
   input  logic [31:0] req0_b,
   input  logic [2:0]  req0_rnd,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [31:0] req1_a,
   input  logic [31:0] req1_b,
   input  logic [2:0]  req1_rnd,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_z,
   output logic        out_id,
   output logic [7:0]  out_status
);

   typedef enum logic [2:0] {IDLE, MULT, NORM, ROUND, DONE} state_t;
   typedef struct packed {
      logic        special;
      logic [7:0]  status;
      logic [31:0] z;
   } spec_t;

   // Special-operand result; denormals are treated as zero.
   function automatic spec_t classify(input logic [31:0] a, input logic [31:0] b);
      logic  a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, s;
      spec_t r;
      a_nan  = (&a[30:23]) & (|a[22:0]);
      b_nan  = (&b[30:23]) & (|b[22:0]);
      a_inf  = (&a[30:23]) & ~(|a[22:0]);
      b_inf  = (&b[30:23]) & ~(|b[22:0]);
      a_zero = ~(|a[30:23]);
      b_zero = ~(|b[30:23]);
      s      = a[31] ^ b[31];
      r      = '0;
      if (a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero)) begin
         r.special = 1'b1; r.status = 8'h04; r.z = 32'h7FC0_0000;
      end else if (a_inf | b_inf) begin
         r.special = 1'b1; r.status = 8'h02; r.z = {s, 8'hFF, 23'd0};
      end else if (a_zero | b_zero) begin
         r.special = 1'b1; r.status = 8'h01; r.z = {s, 31'd0};
      end
      return r;
   endfunction

   state_t             state_q, state_d;
   logic               ptr_q, ptr_d;          // last-served requester
   logic [31:0]        a_q, a_d, b_q, b_d;
   logic [2:0]         rnd_q, rnd_d;
   logic               id_q, id_d;
   logic [47:0]        prod_q, prod_d;
   logic signed [9:0]  exp_q, exp_d;
   logic [23:0]        mant_q, mant_d;
   logic               guard_q, guard_d, sticky_q, sticky_d;
   logic               out_valid_q, out_valid_d;
   logic [31:0]        out_z_q, out_z_d;
   logic               out_id_q, out_id_d;
   logic [7:0]         out_status_q, out_status_d;

   logic               grant1, accept, sign, inexact, inc, ovf_inf;
   logic [24:0]        mant_r;
   logic [22:0]        frac_r;
   logic signed [9:0]  exp_r;
   spec_t              spec_cur;

   // req1 wins if alone, or on contention when req0 was served last.
   assign grant1     = req1_valid & (~req0_valid | ~ptr_q);
   assign req0_ready = (state_q == IDLE) & ~rst & req0_valid & ~grant1;
   assign req1_ready = (state_q == IDLE) & ~rst & grant1;
   assign accept     = req0_ready | req1_ready;

   assign out_valid  = out_valid_q;
   assign out_z      = out_z_q;
   assign out_id     = out_id_q;
   assign out_status = out_status_q;

   assign spec_cur   = classify(a_q, b_q);

`ifdef FP_MULT_CTRL_FAST_SPECIAL_EN
   spec_t spec_in;
   assign spec_in = classify(grant1 ? req1_a : req0_a, grant1 ? req1_b : req0_b);
`endif

   // Rounding of the normalized mantissa held in mant_q/guard_q/sticky_q.
   always_comb begin
      sign    = a_q[31] ^ b_q[31];
      inexact = guard_q | sticky_q;
      case (rnd_q)
         3'b001:  inc = 1'b0;
         3'b010:  inc = inexact & ~sign;
         3'b011:  inc = inexact & sign;
         3'b100:  inc = guard_q;
         default: inc = guard_q & (sticky_q | mant_q[0]);
      endcase
      mant_r = {1'b0, mant_q} + {24'd0, inc};
      // Carry-out leaves 1.000..0, so the fraction is all zeros either way.
      frac_r = mant_r[24] ? mant_r[23:1] : mant_r[22:0];
      exp_r  = exp_q + (mant_r[24] ? 10'sd1 : 10'sd0);
      case (rnd_q)
         3'b001:  ovf_inf = 1'b0;
         3'b010:  ovf_inf = ~sign;
         3'b011:  ovf_inf = sign;
         default: ovf_inf = 1'b1;
      endcase
   end

   always_comb begin
      state_d      = state_q;
      ptr_d        = ptr_q;
      a_d          = a_q;
      b_d          = b_q;
      rnd_d        = rnd_q;
      id_d         = id_q;
      prod_d       = prod_q;
      exp_d        = exp_q;
      mant_d       = mant_q;
      guard_d      = guard_q;
      sticky_d     = sticky_q;
      out_valid_d  = out_valid_q;
      out_z_d      = out_z_q;
      out_id_d     = out_id_q;
      out_status_d = out_status_q;
      case (state_q)
         IDLE: if (accept) begin
            a_d     = grant1 ? req1_a : req0_a;
            b_d     = grant1 ? req1_b : req0_b;
            rnd_d   = grant1 ? req1_rnd : req0_rnd;
            id_d    = grant1;
            ptr_d   = grant1;
            state_d = MULT;
`ifdef FP_MULT_CTRL_FAST_SPECIAL_EN
            if (spec_in.special) begin
               state_d      = DONE;
               out_valid_d  = 1'b1;
               out_z_d      = spec_in.z;
               out_status_d = spec_in.status;
               out_id_d     = grant1;
            end
`endif
         end
         MULT: begin
            prod_d  = 48'({1'b1, a_q[22:0]}) * 48'({1'b1, b_q[22:0]});
            exp_d   = $signed({2'b00, a_q[30:23]}) + $signed({2'b00, b_q[30:23]}) - 10'sd127;
            state_d = NORM;
         end
         NORM: begin
            if (prod_q[47]) begin
               mant_d   = prod_q[47:24];
               guard_d  = prod_q[23];
               sticky_d = |prod_q[22:0];
               exp_d    = exp_q + 10'sd1;
            end else begin
               mant_d   = prod_q[46:23];
               guard_d  = prod_q[22];
               sticky_d = |prod_q[21:0];
            end
            state_d = ROUND;
         end
         ROUND: begin
            out_valid_d = 1'b1;
            out_id_d    = id_q;
            state_d     = DONE;
            // Special operands ran through the datapath only for timing.
            if (spec_cur.special) begin
               out_z_d      = spec_cur.z;
               out_status_d = spec_cur.status;
            end else if (exp_r > 10'sd254) begin
               out_z_d      = {sign, ovf_inf ? {8'hFF, 23'd0} : {8'hFE, 23'h7F_FFFF}};
               out_status_d = 8'h30;
            end else if (exp_r < 10'sd1) begin
               out_z_d      = {sign, 31'd0};
               out_status_d = 8'h29;
            end else begin
               out_z_d      = {sign, exp_r[7:0], frac_r};
               out_status_d = {2'b00, inexact, 5'b00000};
            end
         end
         DONE: if (out_ready) begin
            out_valid_d = 1'b0;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         ptr_q        <= 1'b1;
         a_q          <= '0;
         b_q          <= '0;
         rnd_q        <= '0;
         id_q         <= 1'b0;
         prod_q       <= '0;
         exp_q        <= '0;
         mant_q       <= '0;
         guard_q      <= 1'b0;
         sticky_q     <= 1'b0;
         out_valid_q  <= 1'b0;
         out_z_q      <= '0;
         out_id_q     <= 1'b0;
         out_status_q <= '0;
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         a_q          <= a_d;
         b_q          <= b_d;
         rnd_q        <= rnd_d;
         id_q         <= id_d;
         prod_q       <= prod_d;
         exp_q        <= exp_d;
         mant_q       <= mant_d;
         guard_q      <= guard_d;
         sticky_q     <= sticky_d;
         out_valid_q  <= out_valid_d;
         out_z_q      <= out_z_d;
         out_id_q     <= out_id_d;
         out_status_q <= out_status_d;
      end
   end

endmodule

// File: tb/tb_fp_mult_ctrl.sv
// Scoreboard bench for fp_mult_ctrl: a negedge monitor pushes the reference
// result of every accepted request and pops/compares on each out handshake.
// It also tracks arbitration, latency and output hold under backpressure.
module tb_fp_mult_ctrl;

`ifdef FP_MULT_CTRL_FAST_SPECIAL_EN
   localparam bit FAST = 1'b1;
`else
   localparam bit FAST = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        req0_valid, req0_ready, req1_valid, req1_ready;
   logic [31:0] req0_a, req0_b, req1_a, req1_b;
   logic [2:0]  req0_rnd, req1_rnd;
   logic        out_valid, out_ready, out_id;
   logic [31:0] out_z;
   logic [7:0]  out_status;

   always #5 clk = ~clk;

   fp_mult_ctrl dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_rnd(req0_rnd),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_rnd(req1_rnd),
      .out_valid(out_valid), .out_ready(out_ready), .out_z(out_z), .out_id(out_id), .out_status(out_status)
   );

   typedef struct {
      logic        id;
      logic [31:0] z;
      logic [7:0]  st;
      int          acc;
      bit          fast;
   } exp_t;

   exp_t        sb[$];
   int          vecs = 0, errs = 0, cyc = 0, acc_cnt = 0;
   bit          busy = 0, ptr = 1, seen = 0, stall = 0;
   logic [31:0] pz, last_z;
   logic [7:0]  pst, last_st;
   logic        pid, last_id, last_acc_id;

   function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
      vecs++;
      if (act !== expv) begin
         errs++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", nm, act, expv, cyc);
      end
   endfunction

   function automatic void timeout(input string nm);
      vecs++;
      errs++;
      $display("FAIL %s: timed out (cycle %0d)", nm, cyc);
   endfunction

   // Reference: exact integer product rounded to 24 significant bits by
   // comparing the discarded remainder against half an ulp.
   function automatic logic [39:0] model(input logic [31:0] a, input logic [31:0] b, input logic [2:0] rnd);
      int              ea, eb, e, k;
      logic            s, inexact, inc, to_inf;
      logic [2:0]      m;
      longint unsigned p, q, rem, half;
      ea = int'(a[30:23]);
      eb = int'(b[30:23]);
      s  = a[31] ^ b[31];
      m  = (rnd > 3'd4) ? 3'd0 : rnd;
      if ((ea == 255 && a[22:0] != 0) || (eb == 255 && b[22:0] != 0) ||
          (ea == 255 && eb == 0) || (eb == 255 && ea == 0))
         return {8'h04, 32'h7FC0_0000};
      if (ea == 255 || eb == 255) return {8'h02, s, 8'hFF, 23'd0};
      if (ea == 0 || eb == 0) return {8'h01, s, 31'd0};
      p    = {40'd0, 1'b1, a[22:0]} * {40'd0, 1'b1, b[22:0]};
      k    = (p >= (64'd1 << 47)) ? 24 : 23;
      e    = ea + eb - 127 + (k - 23);
      q    = p >> k;
      rem  = p - (q << k);
      half = 64'd1 << (k - 1);
      inexact = (rem != 0);
      case (m)
         3'd0:    inc = (rem > half) || (rem == half && q[0]);
         3'd1:    inc = 1'b0;
         3'd2:    inc = inexact && !s;
         3'd3:    inc = inexact && s;
         default: inc = (rem >= half);
      endcase
      q = q + 64'(inc);
      if (q == (64'd1 << 24)) begin
         q = q >> 1;
         e++;
      end
      if (e > 254) begin
         case (m)
            3'd1:    to_inf = 1'b0;
            3'd2:    to_inf = !s;
            3'd3:    to_inf = s;
            default: to_inf = 1'b1;
         endcase
         return {8'h30, s, to_inf ? 31'h7F80_0000 : 31'h7F7F_FFFF};
      end
      if (e < 1) return {8'h29, s, 31'd0};
      return {inexact ? 8'h20 : 8'h00, s, e[7:0], q[22:0]};
   endfunction

   function automatic bit is_special(input logic [31:0] a, input logic [31:0] b);
      return (a[30:23] == 8'h00) || (a[30:23] == 8'hFF) || (b[30:23] == 8'h00) || (b[30:23] == 8'hFF);
   endfunction

   // Expected {req1_ready, req0_ready} in IDLE given the last-served requester.
   function automatic logic [1:0] exp_grant(input logic v0, input logic v1, input bit last);
      if (v0 && v1) return last ? 2'b01 : 2'b10;
      return {v1, v0};
   endfunction

   function automatic void enq(input logic id, input logic [31:0] a, input logic [31:0] b, input logic [2:0] rnd);
      logic [39:0] r;
      exp_t        e;
      r      = model(a, b, rnd);
      e.id   = id;
      e.z    = r[31:0];
      e.st   = r[39:32];
      e.acc  = cyc;
      e.fast = FAST && is_special(a, b);
      sb.push_back(e);
      ptr         = id;
      busy        = 1;
      last_acc_id = id;
      acc_cnt++;
   endfunction

   // Monitor: everything sampled on the falling edge.
   always @(negedge clk) begin
      cyc++;
      if (rst) begin
         chk("rst_out_valid", 64'(out_valid), 64'd0);
         chk("rst_ready", 64'({req1_ready, req0_ready}), 64'd0);
         sb.delete();
         busy  = 0;
         ptr   = 1;
         seen  = 0;
         stall = 0;
      end else begin
         chk("ready", 64'({req1_ready, req0_ready}),
             64'(busy ? 2'b00 : exp_grant(req0_valid, req1_valid, ptr)));
         if (req0_valid && req0_ready) enq(1'b0, req0_a, req0_b, req0_rnd);
         else if (req1_valid && req1_ready) enq(1'b1, req1_a, req1_b, req1_rnd);
         if (out_valid) begin
            if (sb.size() == 0) begin
               chk("spurious_out_valid", 64'(out_valid), 64'd0);
            end else begin
               if (!seen) begin
                  chk("latency", 64'(cyc - sb[0].acc), sb[0].fast ? 64'd1 : 64'd4);
                  seen = 1;
               end
               if (stall) begin
                  chk("hold_z", 64'(out_z), 64'(pz));
                  chk("hold_id", 64'(out_id), 64'(pid));
                  chk("hold_status", 64'(out_status), 64'(pst));
               end
               if (out_ready) begin
                  chk("out_z", 64'(out_z), 64'(sb[0].z));
                  chk("out_id", 64'(out_id), 64'(sb[0].id));
                  chk("out_status", 64'(out_status), 64'(sb[0].st));
                  last_z  = out_z;
                  last_st = out_status;
                  last_id = out_id;
                  void'(sb.pop_front());
                  busy = 0;
                  seen = 0;
               end
            end
         end
         stall = out_valid && !out_ready;
         pz    = out_z;
         pid   = out_id;
         pst   = out_status;
      end
   end

   task automatic issue(input logic id, input logic [31:0] a, input logic [31:0] b, input logic [2:0] rnd);
      int n;
      bit got;
      n   = 0;
      got = 0;
      if (id) begin req1_valid = 1; req1_a = a; req1_b = b; req1_rnd = rnd; end
      else    begin req0_valid = 1; req0_a = a; req0_b = b; req0_rnd = rnd; end
      while (!got && n < 100) begin
         @(negedge clk);
         n++;
         got = id ? (req1_valid && req1_ready) : (req0_valid && req0_ready);
      end
      if (!got) timeout("issue");
      @(posedge clk); #1;
      req0_valid = 0;
      req1_valid = 0;
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while ((busy || sb.size() != 0) && n < 300) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 300) timeout("drain");
   endtask

   task automatic tp(input logic id, input logic [31:0] a, input logic [31:0] b, input logic [2:0] rnd,
                     input logic [31:0] ez, input logic [7:0] est);
      issue(id, a, b, rnd);
      wait_drain();
      chk("tp_z", 64'(last_z), 64'(ez));
      chk("tp_status", 64'(last_st), 64'(est));
      chk("tp_id", 64'(last_id), 64'(id));
   endtask

   function automatic logic [31:0] rand_op();
      logic [31:0] r;
      logic [7:0]  e;
      r = $urandom();
      case ($urandom_range(0, 11))
         0:       return {r[31], 31'd0};
         1:       return {r[31], 8'hFF, 23'd0};
         2:       return {r[31], 8'hFF, r[22:1], 1'b1};
         3:       return {r[31], 8'h00, r[22:0]};
         4, 5:    e = 8'($urandom_range(190, 254));
         6, 7:    e = 8'($urandom_range(1, 70));
         8, 9:    begin e = 8'($urandom_range(100, 150)); r[15:0] = 16'd0; end
         default: e = 8'($urandom_range(1, 254));
      endcase
      return {r[31], e, r[22:0]};
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int base, n;
      rst = 1;
      req0_valid = 0; req1_valid = 0;
      req0_a = 0; req0_b = 0; req0_rnd = 0;
      req1_a = 0; req1_b = 0; req1_rnd = 0;
      out_ready = 1;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_out_z", 64'(out_z), 64'd0);
      chk("reset_out_id", 64'(out_id), 64'd0);
      chk("reset_out_status", 64'(out_status), 64'd0);
      rst = 0;
      @(posedge clk); #1;

      // Continuous contention: grants must alternate 0,1,0,1.
      req0_valid = 1; req0_a = 32'h3FC0_0000; req0_b = 32'h4000_0000; req0_rnd = 0;
      req1_valid = 1; req1_a = 32'h4040_0000; req1_b = 32'hC000_0000; req1_rnd = 0;
      for (int g = 0; g < 4; g++) begin
         base = acc_cnt;
         n    = 0;
         while (acc_cnt == base && n < 50) begin @(posedge clk); #1; n++; end
         if (acc_cnt == base) timeout("rr_grant");
         chk("rr_order", 64'(last_acc_id), 64'(g % 2));
      end
      req0_valid = 0; req1_valid = 0;
      wait_drain();

      tp(0, 32'h3FC0_0000, 32'h4000_0000, 3'b000, 32'h4040_0000, 8'h00);
      tp(1, 32'h3F80_0001, 32'h3F80_0001, 3'b000, 32'h3F80_0002, 8'h20);
      tp(0, 32'h3F80_0001, 32'h3F80_0001, 3'b010, 32'h3F80_0003, 8'h20);
      tp(1, 32'h3F80_0001, 32'h3F80_0001, 3'b001, 32'h3F80_0002, 8'h20);
      tp(0, 32'h7F00_0000, 32'h4000_0000, 3'b000, 32'h7F80_0000, 8'h30);
      tp(1, 32'h7F00_0000, 32'h4000_0000, 3'b001, 32'h7F7F_FFFF, 8'h30);
      tp(0, 32'hFF00_0000, 32'h4000_0000, 3'b010, 32'hFF7F_FFFF, 8'h30);
      tp(1, 32'h7F80_0000, 32'h0000_0000, 3'b000, 32'h7FC0_0000, 8'h04);
      tp(0, 32'hFF80_0000, 32'h3F80_0000, 3'b000, 32'hFF80_0000, 8'h02);
      tp(1, 32'h8000_0000, 32'h3F80_0000, 3'b000, 32'h8000_0000, 8'h01);
      tp(0, 32'h0080_0000, 32'h0080_0000, 3'b000, 32'h0000_0000, 8'h29);
      tp(1, 32'h3F80_0003, 32'h3FC0_0000, 3'b000, 32'h3FC0_0004, 8'h20);
      tp(0, 32'h3F80_0003, 32'h3FC0_0000, 3'b100, 32'h3FC0_0005, 8'h20);
      tp(1, 32'h3F80_0003, 32'h3FC0_0000, 3'b111, 32'h3FC0_0004, 8'h20);

      // Backpressure: result parked in DONE for 10 cycles with req1 waiting.
      out_ready = 0;
      issue(0, 32'h3FC0_0000, 32'h4000_0000, 3'b000);
      n = 0;
      while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
      if (!out_valid) timeout("bp_valid");
      req1_valid = 1; req1_a = 32'h4000_0000; req1_b = 32'h4000_0000; req1_rnd = 0;
      repeat (10) begin @(posedge clk); #1; end
      out_ready = 1;
      req1_valid = 0;
      wait_drain();
      chk("bp_z", 64'(last_z), 64'h4040_0000);

      // Reset while in ROUND after a req0 op: contention must then go to req0.
      issue(0, 32'h3FC0_0000, 32'h4000_0000, 3'b000);
      @(posedge clk);
      @(posedge clk); #1;
      rst = 1;
      @(posedge clk); #1;
      base = acc_cnt;
      rst = 0;
      req0_valid = 1; req1_valid = 1;
      n = 0;
      while (acc_cnt == base && n < 50) begin @(posedge clk); #1; n++; end
      if (acc_cnt == base) timeout("rst_grant");
      req0_valid = 0; req1_valid = 0;
      chk("rst_grant", 64'(last_acc_id), 64'd0);
      wait_drain();

      // Randomized traffic with random backpressure.
      for (int c = 0; c < 4000; c++) begin
         @(posedge clk); #1;
         req0_valid = ($urandom_range(0, 3) != 0);
         req0_a = rand_op(); req0_b = rand_op(); req0_rnd = 3'($urandom_range(0, 7));
         req1_valid = ($urandom_range(0, 3) != 0);
         req1_a = rand_op(); req1_b = rand_op(); req1_rnd = 3'($urandom_range(0, 7));
         out_ready = ($urandom_range(0, 3) != 0);
      end
      @(posedge clk); #1;
      req0_valid = 0; req1_valid = 0; out_ready = 1;
      wait_drain();
      repeat (3) @(posedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule

// File: doc/fp_mult_ctrl.md
# fp_mult_ctrl

Sequenced, two-requester single-precision (binary32) multiply unit. Two independent clients share one multiply/normalize/round datapath under round-robin arbitration. Each client supplies its own rounding mode. Results go out on a single valid/ready port, tagged with the requester ID and a status byte. The block sits between the issue logic and the writeback path of the FP cluster.

## Interface
- No parameters; binary32 format fixed.
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- req0_valid / req1_valid  in  1  operand request
- req0_ready / req1_ready  out  1  request accepted when valid&&ready at clk edge
- req0_a, req0_b / req1_a, req1_b  in  32  binary32 operands
- req0_rnd / req1_rnd  in  3  rounding mode
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out_z  out  32  binary32 product
- out_id  out  1  requester that issued this result
- out_status  out  8  [0] zero, [1] inf, [2] nan, [3] tiny, [4] huge, [5] inexact, [7:6] 0

## Operation
- FSM states: IDLE, MULT, NORM, ROUND, DONE. Reset state is IDLE.
- IDLE:
  - Grant is combinational. If only one reqN_valid is high, that requester is granted. If both are high, the requester not served last is granted.
  - The last-served pointer resets to 1, so req0 wins the first contention.
  - Only the granted requester's ready is high. Both readies are low outside IDLE.
- On accept: capture operands, rounding mode and ID; update the pointer; go to MULT.
- MULT: register the 48-bit significand product; exponent sum = ea + eb − 127, held in a 10-bit signed register. Next state NORM.
- NORM:
  - If product[47] is set, shift right 1 and increment the exponent.
  - Form the 24-bit mantissa, guard bit and sticky bit (OR of the remaining bits).
  - Next state ROUND.
- ROUND: apply the rounding mode, then go to DONE.
  - 000: nearest, ties to even.
  - 001: toward zero.
  - 010: toward +inf.
  - 011: toward −inf.
  - 100: nearest, ties away.
  - 101–111: treated as 000.
  - If rounding carries out, shift right 1 and increment the exponent.
- DONE: out_valid high. On out_valid&&out_ready go to IDLE.
- Special cases:
  - Denormal inputs flush to signed zero.
  - Any NaN input, or inf × 0, gives 0x7FC00000 with nan set.
  - inf × finite gives signed inf with inf set.
  - Any zero operand gives signed zero with zero set.
  - Result sign is sa XOR sb; NaN result has sign 0.
- Overflow (rounded exponent > 254): huge and inexact set.
  - Modes 000 and 100 give signed inf.
  - Mode 001 gives signed max normal (0x7F7FFFFF magnitude).
  - Mode 010 gives +inf if positive, else max normal.
  - Mode 011 gives −inf if negative, else max normal.
- Underflow (rounded exponent < 1): flush to signed zero; tiny, inexact and zero set.
- inexact is set whenever guard|sticky is nonzero. An exact nonzero result has status 0.

## Timing
- Reset values: out_valid 0, out_z 0, out_id 0, out_status 0, req0_ready/req1_ready 0 while rst is high, pointer 1, state IDLE.
- Latency: accept at edge T0; out_valid rises after edge T0+3, i.e. the 4th cycle after accept.
- Throughput: at most one operation per 5 cycles (4 cycles of latency plus the return to IDLE).
- Backpressure: while out_valid && !out_ready, out_z, out_id and out_status are held stable and both readies stay low.
- After the out handshake at edge Tn, a new request can be accepted at edge Tn+1 at the earliest.
- reqN_valid may drop without acceptance; a non-accepted request carries no state.
- rst asserted in any state: that cycle goes to IDLE, out_valid=0, in-flight operation discarded, pointer=1.

## Configuration
- FP_MULT_CTRL_FAST_SPECIAL_EN defined:
  - Operands classified special at accept (NaN, inf, zero, denormal) go IDLE → DONE directly, so out_valid rises 1 cycle after accept.
  - Normal operands are unchanged (4-cycle latency).
- Undefined: every operation traverses MULT/NORM/ROUND, so latency is 4 for all operands. Results are bit-identical in both builds.

## Test plan
- req0 a=0x3FC00000 (1.5), b=0x40000000 (2.0), rnd=000 → out_z=0x40400000, out_id=0, status=0x00, out_valid 4 cycles after accept.
- Both requesters valid continuously, out_ready=1 → grants 0,1,0,1 in sequence; each requester's ready is high only in its granted IDLE cycle.
- a=b=0x3F800001:
  - rnd=000 → 0x3F800002, status 0x20.
  - rnd=010 → 0x3F800003.
  - rnd=001 → 0x3F800002.
- a=0x7F000000, b=0x40000000:
  - rnd=000 → 0x7F800000, status 0x30.
  - rnd=001 → 0x7F7FFFFF, status 0x30.
- a=0x7F800000, b=0x00000000 → 0x7FC00000, status 0x04; latency 1 with FP_MULT_CTRL_FAST_SPECIAL_EN, 4 without.
- Backpressure and reset:
  - Hold out_ready=0 for 10 cycles in DONE → out_z stable, both readies low.
  - Separately, pulse rst while in ROUND → out_valid 0 next cycle, state IDLE, the next contention is granted to req0.
